// File: rtl/log_mel.sv
// Log2 stage for mel energies: 3-stage Mitchell approximation with band/frame
// indexing assigned at the output so that flushed samples never consume an index.
module log_mel #(
  parameter int WIDTH     = 16,
  parameter int IN_FRAC   = 15,
  parameter int FRAC_BITS = 10,
  parameter int MEL_BANDS = 40,
  parameter int N_FRAMES  = 101,
  parameter int LOG_FLOOR = -16384
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mel_avail,
  input  logic [WIDTH-1:0]             mel_data,
  output logic                         log_vld,
  output logic [WIDTH-1:0]             log_data,
  output logic [$clog2(MEL_BANDS)-1:0] band_idx,
  output logic [$clog2(N_FRAMES)-1:0]  frame_idx,
  output logic                         frame_last,
  output logic                         utt_done
);

  localparam int BW = $clog2(MEL_BANDS);
  localparam int FW = $clog2(N_FRAMES);
  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0] MSB_POS = PW'(WIDTH - 1);

  // Stage 1: capture sample and zero flag
  logic             v1;
  logic [WIDTH-1:0] s1_data;
  logic             s1_zero;

  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else     v1 <= mel_avail && !start;
  end

  // NOTE: datapath registers carry no reset; only the valid bits decide whether they are observed.
  always_ff @(posedge clk) begin
    if (mel_avail) begin
      s1_data <= mel_data;
      s1_zero <= (mel_data == '0);
    end
  end

  // Stage 2: leading-one position and mantissa directly below it
  logic [PW-1:0]        lead_pos;
  logic [FRAC_BITS-1:0] mant;

  // NOTE: lead_pos gets a default before the loop so the search never infers a latch.
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < WIDTH; i++)
      if (s1_data[i]) lead_pos = PW'(i);
  end

  // Left-justify the leading one to the MSB, then keep the FRAC_BITS bits under it.
  assign mant = FRAC_BITS'((s1_data << (MSB_POS - lead_pos)) >> (WIDTH - 1 - FRAC_BITS));

  logic                 v2;
  logic [PW-1:0]        s2_pos;
  logic [FRAC_BITS-1:0] s2_mant;
  logic                 s2_zero;

  always_ff @(posedge clk) begin
    if (rst) v2 <= 1'b0;
    else     v2 <= v1 && !start;
  end

  always_ff @(posedge clk) begin
    if (v1) begin
      s2_pos  <= lead_pos;
      s2_mant <= mant;
      s2_zero <= s1_zero;
    end
  end

  // Stage 3: result, index assignment and frame/utterance flags
  logic [WIDTH-1:0] log_res;
  logic [BW-1:0]    band_cnt;
  logic [FW-1:0]    frame_cnt;
  logic             last_band;
  logic             last_frame;

  always_comb begin
    log_res = WIDTH'((int'(s2_pos) - IN_FRAC) * (1 << FRAC_BITS) + int'(s2_mant));
    if (s2_zero) log_res = WIDTH'(LOG_FLOOR);
  end

  assign last_band  = (band_cnt == BW'(MEL_BANDS - 1));
  assign last_frame = (frame_cnt == FW'(N_FRAMES - 1));

  // NOTE: all state below updates with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      log_vld    <= 1'b0;
      log_data   <= '0;
      band_idx   <= '0;
      frame_idx  <= '0;
      frame_last <= 1'b0;
      utt_done   <= 1'b0;
      band_cnt   <= '0;
      frame_cnt  <= '0;
    end else begin
      log_vld    <= 1'b0;
      frame_last <= 1'b0;
      utt_done   <= 1'b0;
      if (start) begin
        band_cnt  <= '0;
        frame_cnt <= '0;
      end else if (v2) begin
        log_vld    <= 1'b1;
        log_data   <= log_res;
        band_idx   <= band_cnt;
        frame_idx  <= frame_cnt;
        frame_last <= last_band;
        utt_done   <= last_band && last_frame;
        if (last_band) begin
          band_cnt  <= '0;
          frame_cnt <= last_frame ? '0 : frame_cnt + FW'(1);
        end else begin
          band_cnt <= band_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: doc/log_mel.md
LOG_MEL -- requirements
Module: log_mel

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the input and output sample width.
REQ-002 SHALL have parameter IN_FRAC, default 15, meaning the fractional bits of the unsigned mel input (Q1.15).
REQ-003 SHALL have parameter FRAC_BITS, default 10, meaning the fractional bits of the signed log2 output.
REQ-004 SHALL have parameter MEL_BANDS, default 40, meaning the mel bands per frame.
REQ-005 SHALL have parameter N_FRAMES, default 101, meaning the frames per utterance.
REQ-006 SHALL have parameter LOG_FLOOR, default -16384, meaning the output code for a zero input.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port start, input, 1 bit: a 1-cycle pulse that re-arms the counters and flushes the pipeline.
REQ-010 SHALL have port mel_avail, input, 1 bit: the mel sample valid strobe from the mel filterbank stage.
REQ-011 SHALL have port mel_data, input, WIDTH bits: an unsigned mel energy.
REQ-012 SHALL have port log_vld, output, 1 bit: the log sample valid strobe.
REQ-013 SHALL have port log_data, output, WIDTH bits: signed log2(mel_data) in Q(WIDTH-FRAC_BITS).FRAC_BITS.
REQ-014 SHALL have port band_idx, output, clog2(MEL_BANDS) bits: the band index of log_data.
REQ-015 SHALL have port frame_idx, output, clog2(N_FRAMES) bits: the frame index of log_data.
REQ-016 SHALL have port frame_last, output, 1 bit: asserted with the last band of each frame.
REQ-017 SHALL have port utt_done, output, 1 bit: a 1-cycle pulse with the last band of frame N_FRAMES-1.

Function
REQ-018 SHALL accept one sample on every cycle mel_avail=1, with no backpressure and no gaps required.
REQ-019 SHALL be a 3-stage pipeline: S1 registers data and a zero flag; S2 detects the leading one p (0..WIDTH-1) and normalises; S3 forms the result.
REQ-020 SHALL assert log_vld exactly 3 cycles after the accepting mel_avail cycle, with band_idx, frame_idx, frame_last and utt_done aligned to it.
REQ-021 SHALL compute mant as the FRAC_BITS bits immediately below the leading one, left-aligned and zero-padded when p<FRAC_BITS, truncated and not rounded.
REQ-022 SHALL output log_data = (p-IN_FRAC)*2^FRAC_BITS + mant (Mitchell approximation), two's complement.
REQ-023 SHALL output log_data = LOG_FLOOR when mel_data=0.
REQ-024 SHALL give the result without saturation at the default parameters; the range -15360..+1023 fits in 16-bit signed.
REQ-025 SHALL increment band_idx per output sample and wrap MEL_BANDS-1 to 0; frame_idx SHALL increment on that wrap.
REQ-026 SHALL, after the band wrap at frame_idx=N_FRAMES-1, return frame_idx to 0, pulse utt_done, and continue counting.
REQ-027 SHALL hold log_data and the indices stable when log_vld=0.
REQ-028 SHALL, on start=1: clear the counters, drop all in-flight samples, and set log_vld=0 for the next 3 cycles.
REQ-029 SHALL, on start=1 with mel_avail=1 in the same cycle, give start priority and drop that sample.
REQ-030 SHALL treat the counters as assigned at the output stage, so that samples dropped by start never consume an index.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, clear log_vld, frame_last, utt_done, log_data, band_idx, frame_idx and all pipeline valids to 0.
REQ-032 SHALL, on rst asserted mid-frame, discard in-flight samples, and the first sample after rst falls SHALL be band 0 of frame 0.
REQ-033 SHALL give rst priority over start and mel_avail.

Verification
REQ-034 Single samples: 0x4000 -> log_data 0xFC00; 0x6000 -> 0xFE00; 0x0001 -> 0xC400; 0xFFFF -> 0x03FF; 0x0000 -> 0xC000; each appears 3 cycles after mel_avail.
REQ-035 Back-to-back stream of 40 samples -> 40 consecutive log_vld cycles, band_idx 0..39, frame_last only on band 39, frame_idx increments to 1 afterwards.
REQ-036 Full 101x40 stream -> a single utt_done pulse coincident with frame_idx=100, band_idx=39; the next sample reports frame 0, band 0.
REQ-037 start with mel_avail in the same cycle, mid-frame at band 17 -> that sample and 2 in-flight samples are dropped, and the next accepted sample outputs band 0, frame 0.
REQ-038 rst pulse at band 25 of frame 3 -> all outputs 0 next cycle, no log_vld for dropped samples, and indices restart at 0/0.
REQ-039 Random valid gaps -> log_data matches a bit-exact Mitchell model with index ordering preserved.
